// File: rtl/rising_edge_d_flip_flop.sv
// Positive-edge D register, WIDTH bits, synchronous active-high reset to RESET_VALUE.
// Latency 1 clk; no flow control or backpressure. Q is driven straight from the flop.
module rising_edge_d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Reset wins over data when both are present at the same edge.
    always_comb begin
        q_d = D;
        if (reset) begin
            q_d = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: tb/tb_rising_edge_d_flip_flop.sv
// Bench for rising_edge_d_flip_flop: directed timeline, table vectors on an 8-bit
// instance, and randomized traffic checked against a reference model.
module tb_rising_edge_d_flip_flop;

    logic       clk;
    logic       r1;
    logic       d1;
    logic       q1;
    logic       r8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks;
    int errors;

    rising_edge_d_flip_flop u_dut1 (
        .D     (d1),
        .clk   (clk),
        .reset (r1),
        .Q     (q1)
    );

    rising_edge_d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .D     (d8),
        .clk   (clk),
        .reset (r8),
        .Q     (q8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[$];
        logic [7:0] exp8;
        logic       exp1;
        logic [7:0] junk;

        checks = 0;
        errors = 0;
        r1 = 1'b1;
        d1 = 1'b0;
        r8 = 1'b1;
        d8 = 8'h00;

        // Power-up reset and release between edges
        tick();                                   // t = 11
        check("por_q1", {7'b0, q1}, 8'h00);
        check("por_q8", q8, 8'hA5);
        #2 r1 = 1'b0;                             // t = 13
        tick();                                   // t = 31
        check("post_rst_d0", {7'b0, q1}, 8'h00);

        // Capture and one-cycle latency
        d1 = 1'b1;
        tick();                                   // t = 51
        check("cap_1", {7'b0, q1}, 8'h01);
        d1 = 1'b0;
        tick();
        check("cap_0", {7'b0, q1}, 8'h00);
        tick();
        check("cap_0_hold", {7'b0, q1}, 8'h00);
        d1 = 1'b1;
        tick();
        check("cap_1_again", {7'b0, q1}, 8'h01);
        for (int i = 0; i < 26; i++) begin
            tick();
            check("hold_d1", {7'b0, q1}, 8'h01);
        end

        // Reset asserted mid-cycle must wait for the edge
        #2 r1 = 1'b1;
        #3 check("rst_mid_no_async", {7'b0, q1}, 8'h01);
        @(negedge clk);
        #1 check("rst_negedge_no_effect", {7'b0, q1}, 8'h01);
        tick();
        check("rst_at_edge", {7'b0, q1}, 8'h00);
        #4 r1 = 1'b0;
        tick();
        check("rst_release_loads_d", {7'b0, q1}, 8'h01);

        // Reset priority over data, held across toggling D
        r1 = 1'b1;
        d1 = 1'b1;
        tick();
        check("rst_prio", {7'b0, q1}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            d1 = ~d1;
            tick();
            check("rst_hold", {7'b0, q1}, 8'h00);
        end
        r1 = 1'b0;
        d1 = 1'b0;
        tick();
        check("after_rst_d0", {7'b0, q1}, 8'h00);

        // Glitch between edges and falling-edge immunity
        #3 d1 = 1'b1;
        #3 d1 = 1'b0;
        check("glitch_mid", {7'b0, q1}, 8'h00);
        tick();
        check("glitch_edge", {7'b0, q1}, 8'h00);
        d1 = 1'b1;
        @(negedge clk);
        #1 check("negedge_ignored", {7'b0, q1}, 8'h00);
        tick();
        check("posedge_captures", {7'b0, q1}, 8'h01);

        // X on D propagates when reset is low
        d1 = 1'bx;
        tick();
        check("x_propagates", {7'b0, q1}, {7'b0, 1'bx});
        d1 = 1'b0;
        tick();
        check("x_cleared", {7'b0, q1}, 8'h00);

        // Table vectors on the 8-bit instance
        vecs.push_back('{1'b1, 8'h3C, 8'hA5});
        vecs.push_back('{1'b0, 8'h3C, 8'h3C});
        vecs.push_back('{1'b0, 8'hFF, 8'hFF});
        vecs.push_back('{1'b1, 8'h00, 8'hA5});
        vecs.push_back('{1'b1, 8'h5A, 8'hA5});
        vecs.push_back('{1'b0, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'hC3, 8'hC3});
        vecs.push_back('{1'b1, 8'hFF, 8'hA5});
        vecs.push_back('{1'b0, 8'hA5, 8'hA5});
        vecs.push_back('{1'b0, 8'h81, 8'h81});
        foreach (vecs[i]) begin
            r8 = vecs[i].rst;
            d8 = vecs[i].d;
            tick();
            check($sformatf("vec%0d", i), q8, vecs[i].exp);
        end

        // Randomized traffic with junk values driven early in each cycle
        exp8 = q8;
        exp1 = q1;
        for (int i = 0; i < 300; i++) begin
            logic       nr1;
            logic       nr8;
            logic       nd1;
            logic [7:0] nd8;
            nr1 = ($urandom_range(7) == 0);
            nr8 = ($urandom_range(7) == 0);
            nd1 = 1'($urandom);
            nd8 = 8'($urandom);
            junk = 8'($urandom);
            d8 = junk;
            d1 = junk[0];
            r1 = junk[1];
            r8 = junk[2];
            #4;
            if (i % 16 == 0) begin
                check("rnd_hold_q8", q8, exp8);
                check("rnd_hold_q1", {7'b0, q1}, {7'b0, exp1});
            end
            r1 = nr1;
            r8 = nr8;
            d1 = nd1;
            d8 = nd8;
            exp1 = nr1 ? 1'b0 : nd1;
            exp8 = nr8 ? 8'hA5 : nd8;
            tick();
            check("rnd_q8", q8, exp8);
            check("rnd_q1", {7'b0, q1}, {7'b0, exp1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rising_edge_d_flip_flop.md
Name: rising_edge_d_flip_flop

Overview:
- Single-bit (width-parameterisable) positive-edge D flip-flop with synchronous, active-high reset.
- Leaf storage primitive for the iCE40 flow examples, used to register a data input onto `clk`.
- Pure register: no enable, no combinational path from `D` to `Q`.

Parameters:
- WIDTH, 1, bit width of `D` and `Q`.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into `Q` when `reset` is sampled high.

Ports:
- clk  input  1  system clock; all state changes on its rising edge only.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of `clk`.
- D  input  WIDTH  data input, sampled on rising edge of `clk`.
- Q  output  WIDTH  registered data output, driven directly from the flop.

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`reset`). Polarity and synchronicity are fixed.
- Declaration order is D, clk, reset, Q, so that positional instantiation `(D, clk, reset, Q)` binds correctly.
- On each rising edge of `clk`:
  - If `reset`=1, then `Q` <= RESET_VALUE.
  - Else `Q` <= `D`.
- Reset has priority over data when both are present at the same edge.
- Latency is exactly 1 clock: the value of `D` sampled at edge N appears on `Q` after edge N and holds until edge N+1.
- Between clock edges, `Q` holds. Changes on `D` or `reset` between edges have no effect on `Q`.
- Reset is not asynchronous:
  - Asserting `reset` between edges does not change `Q` until the next rising edge.
  - Deasserting `reset` between edges means the next edge loads `D`.
- Reset asserted mid-operation: `Q` goes to RESET_VALUE at the first rising edge where `reset`=1, regardless of `D`.
- Power-up, before the first rising edge: `Q` is undefined (X in simulation). Benches must not check `Q` before the first edge with `reset`=1.
- Falling edges of `clk` have no effect.
- `D` sampling uses the value present just before the edge. Stimulus driven with nonblocking assignment at an edge is captured on the following edge.
- No X-propagation masking: X on `D` (reset low) propagates to `Q` at the next edge.
- Synthesises to one SB_DFFSR-class flop per bit (sync reset). No latches; no initial value required by synthesis.

Test Plan:
1. Reset at power-up: 20 ns clock (first rise at 10 ns), `reset`=1, `D`=0 from t=0. At 10 ns edge, `Q`=0. Deassert `reset` at 13 ns; at the 30 ns edge with `D`=0, `Q` stays 0.
2. Data capture and latency: after reset, drive `D`=1 just after the 30 ns edge and `D`=0 just after the 50 ns edge. Expect `Q`=1 after 50 ns, `Q`=0 after 70 ns, `Q`=0 after 90 ns. Drive `D`=1 after 90 ns; expect `Q`=1 from 110 ns onward, stable for 500+ ns with `D` held.
3. Synchronous reset, not async: with `Q`=1 and `D`=1, assert `reset` 3 ns after an edge. `Q` must remain 1 until the next rising edge, then go 0. Deassert mid-cycle; the next edge gives `Q`=1.
4. Reset priority: `reset`=1 and `D`=1 at the same edge gives `Q`=0. Hold `reset`=1 for 3 edges while toggling `D`; `Q` stays 0 throughout.
5. Glitch immunity: toggle `D` 0→1→0 entirely between two rising edges (`reset`=0). `Q` is unchanged at the next edge (captures 0). No change on falling edges.
6. Parameter check: WIDTH=8, RESET_VALUE=8'hA5. Reset gives `Q`=8'hA5; `D`=8'h3C gives `Q`=8'h3C one edge later.
